// File: rtl/segasys1_sndcmd_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | segasys1_sndcmd_rx_if : main-to-sound command channel and sound-CPU bus  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface segasys1_sndcmd_rx_if;
  logic        SNDRQ;
  logic [7:0]  SNDNO;
  logic        SCPU_CLK_EN;
  logic [15:0] SCPU_AD;
  logic        SCPU_MREQ;
  logic        SCPU_RD;
  logic        SCPU_DV;
  logic [7:0]  SCPU_DO;
  logic        SNMI;
  logic        SIRQ;
  logic        OVFL;

  modport master (
    output SNDRQ, SNDNO, SCPU_CLK_EN, SCPU_AD, SCPU_MREQ, SCPU_RD,
    input  SCPU_DV, SCPU_DO, SNMI, SIRQ, OVFL
  );

  modport slave (
    input  SNDRQ, SNDNO, SCPU_CLK_EN, SCPU_AD, SCPU_MREQ, SCPU_RD,
    output SCPU_DV, SCPU_DO, SNMI, SIRQ, OVFL
  );
endinterface
`default_nettype wire

// File: rtl/segasys1_sndcmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | segasys1_sndcmd_rx : sound-CPU command FIFO, edge-per-command NMI and    |
// | periodic IRQ generator.                                   Rev 1.0        |
// +--------------------------------------------------------------------------+
module segasys1_sndcmd_rx #(
  parameter int DEPTH_LOG2 = 2,
  parameter int NMI_GAP    = 8,
  parameter int IRQ_PERIOD = 16384,
  parameter int IRQ_WIDTH  = 64
) (
  input  wire logic           CLK48M,
  input  wire logic           RESET,
  segasys1_sndcmd_rx_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GAP_W = $clog2(NMI_GAP + 1);

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(NMI_GAP);
  localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
  localparam logic [15:0]           IRQ_LAST = 16'(IRQ_PERIOD - 1);
  localparam logic [15:0]           IRQ_HIGH = 16'(IRQ_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } nmi_state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            hold_q;
  logic                  ovfl_q;
  logic                  rd_q;

  nmi_state_e            state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  snmi;

  logic [15:0]           irq_cnt_q;
  logic                  sirq_q;

  logic                  cs;
  logic                  rd_now;
  logic                  pop;
  logic                  push_ok;
  logic                  not_empty;
  logic [7:0]            head;

  // Read decode: the whole $E000-$FFFF window aliases the command latch.
  assign cs        = (bus.SCPU_AD[15:13] == 3'b111) & bus.SCPU_MREQ;
  assign rd_now    = cs & bus.SCPU_RD;
  assign not_empty = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  // Pop on the trailing edge of the read so the data is stable for the cycle.
  assign pop     = rd_q & ~rd_now & not_empty;
  assign push_ok = bus.SNDRQ & ((count_q != CNT_FULL) | pop);

  assign bus.SCPU_DV = rd_now;
  assign bus.SCPU_DO = not_empty ? head : hold_q;
  assign bus.SNMI    = snmi;
  assign bus.SIRQ    = sirq_q;
  assign bus.OVFL    = ovfl_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK48M) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.SNDNO;
    end
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= 8'h00;
      ovfl_q   <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      rd_q    <= rd_now;
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        hold_q   <= head;
      end
      if (bus.SNDRQ & ~push_ok) begin
        ovfl_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Exits use count_d so a pop landing on the same edge cannot leave NMI stuck high.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    snmi    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (not_empty && (count_d != '0)) begin
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        snmi = 1'b1;
        if (pop) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (!not_empty) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = (count_d != '0) ? S_ASSERT : S_IDLE;
        end else if (bus.SCPU_CLK_EN) begin
          gap_d = gap_q - GAP_ONE;
          if (gap_q == GAP_ONE) begin
            state_d = (count_d != '0) ? S_ASSERT : S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      irq_cnt_q <= 16'd0;
      sirq_q    <= 1'b0;
    end else if (bus.SCPU_CLK_EN) begin
      irq_cnt_q <= (irq_cnt_q == IRQ_LAST) ? 16'd0 : irq_cnt_q + 16'd1;
      sirq_q    <= (irq_cnt_q < IRQ_HIGH);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segasys1_sndcmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_segasys1_sndcmd_rx : directed + randomized bench with a queue model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_segasys1_sndcmd_rx;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int NMI_GAP    = 8;
  localparam int IRQ_PERIOD = 1024;
  localparam int IRQ_WIDTH  = 64;
  localparam int EN_DIV     = 8;
  localparam int GAP_BOUND  = NMI_GAP * EN_DIV * 2 + 20;

  logic CLK48M = 1'b0;
  logic RESET  = 1'b1;

  segasys1_sndcmd_rx_if bus();

  segasys1_sndcmd_rx #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NMI_GAP    (NMI_GAP),
    .IRQ_PERIOD (IRQ_PERIOD),
    .IRQ_WIDTH  (IRQ_WIDTH)
  ) dut (
    .CLK48M (CLK48M),
    .RESET  (RESET),
    .bus    (bus)
  );

  initial forever #5 CLK48M = ~CLK48M;

  // Sound CPU clock enable: one cycle in every EN_DIV.
  int en_div_cnt = 0;
  initial begin
    bus.SCPU_CLK_EN = 1'b0;
    forever begin
      @(posedge CLK48M);
      #1;
      en_div_cnt = (en_div_cnt + 1) % EN_DIV;
      bus.SCPU_CLK_EN = (en_div_cnt == 0);
    end
  end

  // Ticks seen by the DUT since reset release.
  int ticks;
  always @(posedge CLK48M or posedge RESET) begin
    if (RESET) ticks <= 0;
    else if (bus.SCPU_CLK_EN) ticks <= ticks + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic [7:0] m_hold;
  logic       m_ovfl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic exp_sirq(input int t);
    return (t > 0) && (((t - 1) % IRQ_PERIOD) < IRQ_WIDTH);
  endfunction

  function automatic logic [7:0] exp_do();
    return (mq.size() != 0) ? mq[0] : m_hold;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovfl = 1'b1;
  endfunction

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.SNDRQ = 1'b0;
    bus.SCPU_RD = 1'b0;
    bus.SCPU_MREQ = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    mq.delete();
    m_hold = 8'h00;
    m_ovfl = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.SNDNO = b;
    bus.SNDRQ = 1'b1;
    tick();
    bus.SNDRQ = 1'b0;
    bus.SNDNO = 8'($urandom);
    model_push(b);
  endtask

  task automatic rd_cmd(input int hold_cyc, input bit push_at_pop, input logic [7:0] pb);
    logic [7:0] expv;
    expv = exp_do();
    bus.SCPU_AD   = {3'b111, 13'($urandom)};
    bus.SCPU_MREQ = 1'b1;
    bus.SCPU_RD   = 1'b1;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge CLK48M);
      chk("rd_dv", bus.SCPU_DV, 1);
      chk("rd_do", bus.SCPU_DO, expv);
      tick();
    end
    bus.SCPU_RD   = 1'b0;
    bus.SCPU_MREQ = 1'b0;
    if (push_at_pop) begin
      bus.SNDNO = pb;
      bus.SNDRQ = 1'b1;
    end
    @(negedge CLK48M);
    chk("rd_dv_off", bus.SCPU_DV, 0);
    tick();
    bus.SNDRQ = 1'b0;
    if (mq.size() != 0) m_hold = mq.pop_front();
    if (push_at_pop) model_push(pb);
  endtask

  task automatic miss_rd();
    logic [7:0] expv;
    expv = exp_do();
    if ($urandom_range(0, 1) == 1) begin
      bus.SCPU_AD   = {3'($urandom_range(0, 6)), 13'($urandom)};
      bus.SCPU_MREQ = 1'b1;
    end else begin
      bus.SCPU_AD   = {3'b111, 13'($urandom)};
      bus.SCPU_MREQ = 1'b0;
    end
    bus.SCPU_RD = 1'b1;
    repeat (2) begin
      @(negedge CLK48M);
      chk("miss_dv", bus.SCPU_DV, 0);
      chk("miss_do", bus.SCPU_DO, expv);
      tick();
    end
    bus.SCPU_RD   = 1'b0;
    bus.SCPU_MREQ = 1'b0;
    tick();
  endtask

  task automatic wait_snmi_high();
    int n;
    n = 0;
    while (bus.SNMI !== 1'b1 && n < GAP_BOUND) begin
      @(negedge CLK48M);
      n++;
    end
    chk("snmi_rise_bound", bus.SNMI, 1);
    tick();
  endtask

  // Counts enable ticks while SNMI is low, until it rises or the bound expires.
  task automatic measure_gap(output int t, output bit rose);
    int n;
    n = 0;
    t = 0;
    rose = 1'b0;
    while (n < GAP_BOUND) begin
      @(negedge CLK48M);
      if (bus.SNMI === 1'b1) begin
        rose = 1'b1;
        break;
      end
      if (bus.SCPU_CLK_EN) t++;
      n++;
    end
    tick();
  endtask

  task automatic irq_test();
    int hi [3];
    int start;
    int n;
    for (int p = 0; p < 3; p++) hi[p] = 0;
    for (int k = 0; k < 3 * IRQ_PERIOD; k++) begin
      start = ticks;
      n = 0;
      while (ticks == start && n < EN_DIV * 2) begin
        @(negedge CLK48M);
        n++;
      end
      if (ticks == start) begin
        chk("irq_tick_bound", ticks, start + 1);
        break;
      end
      chk("sirq", bus.SIRQ, exp_sirq(ticks));
      if (bus.SIRQ === 1'b1) hi[(ticks - 1) / IRQ_PERIOD] += 1;
    end
    for (int p = 0; p < 3; p++) chk("sirq_high_ticks", hi[p], IRQ_WIDTH);
    tick();
  endtask

  initial begin
    int  t;
    bit  rose;
    int  n;
    int  op;
    logic [7:0] b;

    bus.SNDRQ     = 1'b0;
    bus.SNDNO     = 8'h00;
    bus.SCPU_AD   = 16'h0000;
    bus.SCPU_MREQ = 1'b0;
    bus.SCPU_RD   = 1'b0;
    m_hold = 8'h00;
    m_ovfl = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK48M);
    chk("rst_snmi", bus.SNMI, 0);
    chk("rst_sirq", bus.SIRQ, 0);
    chk("rst_ovfl", bus.OVFL, 0);
    chk("rst_do", bus.SCPU_DO, 8'h00);
    chk("rst_dv", bus.SCPU_DV, 0);
    tick();
    do_reset();

    // Single command, NMI latency, read, return to idle
    push(8'h5A);
    @(negedge CLK48M);
    chk("nmi_lat_1", bus.SNMI, 0);
    @(negedge CLK48M);
    chk("nmi_lat_2", bus.SNMI, 1);
    tick();
    rd_cmd($urandom_range(1, 4), 1'b0, 8'h00);
    chk("nmi_drop_after_pop", bus.SNMI, 0);
    measure_gap(t, rose);
    chk("single_idle", rose, 0);
    chk("single_do_hold", bus.SCPU_DO, 8'h5A);

    // Three back-to-back commands, gap between NMI phases
    for (int i = 0; i < 3; i++) push(8'($urandom));
    wait_snmi_high();
    for (int i = 0; i < 3; i++) begin
      rd_cmd($urandom_range(1, 3), 1'b0, 8'h00);
      measure_gap(t, rose);
      if (i < 2) begin
        chk("gap_ticks", t, NMI_GAP);
        chk("gap_rise", rose, 1);
      end else begin
        chk("gap_final_idle", rose, 0);
      end
    end

    // Overflow
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    chk("ovfl_at_full", bus.OVFL, 0);
    push(8'h14);
    chk("ovfl_set", bus.OVFL, 1);
    for (int i = 0; i < 5; i++) rd_cmd($urandom_range(1, 3), 1'b0, 8'h00);
    measure_gap(t, rose);
    chk("ovfl_drain_idle", rose, 0);
    chk("ovfl_hold", bus.SCPU_DO, 8'h13);
    chk("ovfl_sticky", bus.OVFL, 1);

    // Push on the exact pop cycle while full
    do_reset();
    chk("ovfl_cleared", bus.OVFL, 0);
    for (int i = 0; i < 4; i++) push(8'($urandom));
    rd_cmd(2, 1'b1, 8'hAA);
    chk("full_pushpop_ovfl", bus.OVFL, m_ovfl);
    chk("full_pushpop_ovfl0", bus.OVFL, 0);
    for (int i = 0; i < 4; i++) rd_cmd($urandom_range(1, 2), 1'b0, 8'h00);
    chk("full_pushpop_last", m_hold, 8'hAA);
    chk("full_pushpop_do", bus.SCPU_DO, 8'hAA);

    // Periodic IRQ
    do_reset();
    irq_test();

    // Asynchronous reset with commands queued
    do_reset();
    push(8'($urandom));
    push(8'($urandom));
    wait_snmi_high();
    n = 0;
    while (bus.SIRQ !== 1'b1 && n < EN_DIV * 2) begin
      tick();
      n++;
    end
    chk("pre_rst_snmi", bus.SNMI, 1);
    chk("pre_rst_sirq", bus.SIRQ, 1);
    @(negedge CLK48M);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_snmi", bus.SNMI, 0);
    chk("async_rst_sirq", bus.SIRQ, 0);
    chk("async_rst_ovfl", bus.OVFL, 0);
    chk("async_rst_do", bus.SCPU_DO, 8'h00);
    tick();
    tick();
    RESET = 1'b0;
    mq.delete();
    m_hold = 8'h00;
    m_ovfl = 1'b0;
    rd_cmd(1, 1'b0, 8'h00);
    measure_gap(t, rose);
    chk("post_rst_idle", rose, 0);

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        push(8'($urandom));
      end else if (op <= 6) begin
        b = 8'($urandom);
        rd_cmd($urandom_range(1, 3), ($urandom_range(0, 3) == 0), b);
      end else if (op == 7) begin
        miss_rd();
      end else begin
        repeat ($urandom_range(1, 5)) tick();
      end
    end
    chk("rand_ovfl", bus.OVFL, m_ovfl);
    repeat (GAP_BOUND) tick();
    chk("rand_snmi_settled", bus.SNMI, (mq.size() != 0));
    chk("rand_do", bus.SCPU_DO, exp_do());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
